// File: rtl/mod_memaccess.sv
// mod_memaccess: memory-access stage; runs 8-byte loads/stores over a BUS_W-bit request/response port and hands MEM_EX to execute
// Ports: idmem/id_valid/id_ready = decoded instruction in; mem_req_*/mem_resp_* = narrow memory port;
//        memex/can_execute/ex_ready = MEM_EX out; load_buffer/loadbuffer_done = assembled load data;
//        memstage_active/store_memstage_active = memory op in flight.
// idmem = {memex fields[277:0], mem_addr[63:0]}; memex layout: [277:270] ctl_opcode, [269:268] mod,
//        [267] twob, [266] sim_end, [265:202] data_regA, [201:138] data_regB, [137:0] remaining fields.
// Optional: MEMACCESS_STORE_FWD_EN enables last-store-to-load forwarding.
module mod_memaccess #(
  parameter int BUS_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [341:0]      idmem,
  input  logic              id_valid,
  output logic              id_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [BUS_W-1:0]  mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [BUS_W-1:0]  mem_resp_data,
  output logic [277:0]      memex,
  output logic              can_execute,
  input  logic              ex_ready,
  output logic [63:0]       load_buffer,
  output logic              loadbuffer_done,
  output logic              memstage_active,
  output logic              store_memstage_active
);
  localparam int BEATS = 64 / BUS_W;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, OUT = 2'd3;
  logic [1:0] state, beat;
  logic [277:0] held;
  logic [63:0] addr, shadow, lb_next, beat_addr, fwd_data;
  logic is_load_q, dec_load, dec_store, accept, last, fwd_hit;
  logic [7:0] op;
  logic [1:0] md;
  assign op = idmem[341:334];
  assign md = idmem[333:332];
  // twob or sim_end force PASS regardless of opcode
  assign dec_load = !idmem[331] && !idmem[330] && ((op == 8'd139 && md != 2'd3) || op[7:3] == 5'b01011);
  assign dec_store = !idmem[331] && !idmem[330] && ((op == 8'd137 && md != 2'd3) || op[7:3] == 5'b01010);
  // OUT accepts in its ex_ready cycle so a finished op hands over with no bubble
  assign id_ready = (state == IDLE || state == OUT) && (!can_execute || ex_ready);
  assign accept = id_valid && id_ready;
  assign last = beat == 2'(BEATS - 1);
  assign beat_addr = {addr[63:3], 3'b000} + 64'(beat) * 64'(BUS_W / 8);
  assign mem_req_valid = state == REQ && !fwd_hit;
  assign mem_req_write = !is_load_q;
  assign mem_req_addr = ADDR_W'(beat_addr);
  assign mem_req_wdata = held[138 + beat * BUS_W +: BUS_W];
  always_comb begin
    lb_next = shadow;
    lb_next[beat * BUS_W +: BUS_W] = mem_resp_data;
  end
`ifdef MEMACCESS_STORE_FWD_EN
  logic fwd_valid;
  logic [60:0] fwd_addr;
  always_ff @(posedge clk) begin
    if (reset) fwd_valid <= 1'b0;
    else if (state == WAIT && mem_resp_valid && last && !is_load_q) begin
      fwd_valid <= 1'b1;
      fwd_addr <= addr[63:3];
      fwd_data <= held[201:138];
    end
  end
  assign fwd_hit = is_load_q && fwd_valid && fwd_addr == addr[63:3];
`else
  assign fwd_data = '0;
  assign fwd_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    loadbuffer_done <= 1'b0;
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      held <= '0;
      addr <= '0;
      shadow <= '0;
      is_load_q <= 1'b0;
      memex <= '0;
      can_execute <= 1'b0;
      load_buffer <= '0;
      memstage_active <= 1'b0;
      store_memstage_active <= 1'b0;
    end else begin
      if (can_execute && ex_ready) can_execute <= 1'b0;
      if (state == OUT && ex_ready) state <= IDLE;
      if (accept) begin
        if (dec_load || dec_store) begin
          held <= idmem[341:64];
          addr <= idmem[63:0];
          is_load_q <= dec_load;
          beat <= '0;
          state <= REQ;
          memstage_active <= 1'b1;
          store_memstage_active <= dec_store;
        end else begin
          memex <= idmem[341:64];
          can_execute <= 1'b1;
        end
      end
      if (state == REQ && fwd_hit) begin
        state <= OUT;
        memex <= held;
        can_execute <= 1'b1;
        load_buffer <= fwd_data;
        loadbuffer_done <= 1'b1;
        memstage_active <= 1'b0;
      end else if (state == REQ && mem_req_ready) state <= WAIT;
      // load_buffer only changes on the final beat, so an aborted load never leaks partial data
      if (state == WAIT && mem_resp_valid) begin
        shadow <= lb_next;
        if (last) begin
          state <= OUT;
          memex <= held;
          can_execute <= 1'b1;
          memstage_active <= 1'b0;
          store_memstage_active <= 1'b0;
          if (is_load_q) begin
            load_buffer <= lb_next;
            loadbuffer_done <= 1'b1;
          end
        end else begin
          beat <= beat + 2'd1;
          state <= REQ;
        end
      end
    end
  end
endmodule
